// File: rtl/clk_enable_gen_if.sv
// Config write channel for clk_enable_gen.
// One valid/ready handshake carrying a channel index and its new ratio/phase.
interface clk_enable_gen_if #(
    parameter int ACC_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_mod;
    logic [ACC_W-1:0] cfg_phase;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_inc,
        output cfg_mod,
        output cfg_phase,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_inc,
        input  cfg_mod,
        input  cfg_phase,
        output cfg_ready
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator (stb rate = inc/mod).
// Optional square-wave div_out per channel: define CLK_ENABLE_GEN_DIVOUT_EN.
module clk_enable_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 16,
    parameter int DEFAULT_INC = 1,
    parameter int DEFAULT_MOD = 4,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    clk_enable_gen_if.slave     cfg,
    input  logic                restart,
    output logic [NUM_CH-1:0]   stb,
    output logic [NUM_CH-1:0]   ch_err,
    output logic                locked
`ifdef CLK_ENABLE_GEN_DIVOUT_EN
    ,
    output logic [NUM_CH-1:0]   div_out
`endif
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] DEF_INC = ACC_W'(DEFAULT_INC);
    localparam logic [ACC_W-1:0] DEF_MOD = ACC_W'(DEFAULT_MOD);
    localparam bit DEF_BAD = (DEFAULT_MOD == 0) || (DEFAULT_INC == 0) ||
                             (DEFAULT_INC >= DEFAULT_MOD);

    typedef enum logic { SETTLE, LOCKED } lock_t;
    typedef enum logic { IDLE, APPLY } hs_t;

    lock_t            lock_q, lock_d;
    hs_t              hs_q, hs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             wr_bad;

    assign cfg.cfg_ready = (hs_q == IDLE);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign locked        = (lock_q == LOCKED);

    // Validity of the incoming write, latched as ch_err on the accept edge
    assign wr_bad = (cfg.cfg_mod == '0) || (cfg.cfg_inc == '0) ||
                    (cfg.cfg_inc >= cfg.cfg_mod) ||
                    (cfg.cfg_phase >= cfg.cfg_mod);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= SETTLE;
            hs_q   <= IDLE;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            hs_q   <= hs_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        lock_d = lock_q;
        hs_d   = IDLE;
        cnt_d  = cnt_q;
        if (accept) begin
            lock_d = SETTLE;
            hs_d   = APPLY;
            cnt_d  = '0;
        end else if (lock_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                lock_d = LOCKED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] inc_q;
        logic [ACC_W-1:0] mod_q;
        logic [ACC_W-1:0] phase_q;
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W:0]   sum;
        logic             stb_q;
        logic             err_q;
        logic             wr;
        logic             hit;

        // Indices >= NUM_CH never match, so such writes are discarded
        assign wr  = accept && (cfg.cfg_ch == 4'(i));
        assign sum = {1'b0, acc_q} + {1'b0, inc_q};
        assign hit = !err_q && (sum >= {1'b0, mod_q});

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                inc_q   <= DEF_INC;
                mod_q   <= DEF_MOD;
                phase_q <= '0;
                acc_q   <= '0;
                stb_q   <= 1'b0;
                err_q   <= DEF_BAD;
            end else if (wr) begin
                inc_q   <= cfg.cfg_inc;
                mod_q   <= cfg.cfg_mod;
                phase_q <= cfg.cfg_phase;
                acc_q   <= cfg.cfg_phase;
                stb_q   <= 1'b0;
                err_q   <= wr_bad;
            end else if (restart) begin
                acc_q <= phase_q;
                stb_q <= 1'b0;
            end else if (hit) begin
                // sum - mod < inc, so the low ACC_W bits are exact
                acc_q <= sum[ACC_W-1:0] - mod_q;
                stb_q <= 1'b1;
            end else if (!err_q) begin
                acc_q <= sum[ACC_W-1:0];
                stb_q <= 1'b0;
            end else begin
                stb_q <= 1'b0;
            end
        end

        assign stb[i]    = stb_q;
        assign ch_err[i] = err_q;

`ifdef CLK_ENABLE_GEN_DIVOUT_EN
        logic div_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q <= 1'b0;
            end else if (restart) begin
                div_q <= 1'b0;
            end else if (!wr && hit) begin
                div_q <= ~div_q;
            end
        end

        assign div_out[i] = div_q;
`endif
    end

endmodule
